// File: rtl/serial_paralelo.sv
// Serial-to-parallel receiver: comma-based word alignment, lock/loss tracking, 10-bit word output.
// Optional build macro FILTER_COMMA_EN suppresses the word output for comma symbols while locked.
module serial_paralelo #(
    parameter logic [9:0] COMMA_P    = 10'b0011111010,
    parameter logic [9:0] COMMA_N    = 10'b1100000101,
    parameter int         LOCK_COUNT = 3,
    parameter int         LOSS_COUNT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enb,
    input  logic       entrada,
    output logic [9:0] salidas,
    output logic       validoSalida,
    output logic       sincronizado,
    output logic       comaDetectada
);

    // state  | meaning
    // HUNT   | searching the stream for any comma
    // ALIGN  | comma seen, confirming it repeats on the 10-bit boundary
    // LOCKED | aligned; one word presented per boundary
    typedef enum logic [1:0] {HUNT, ALIGN, LOCKED} state_t;

    localparam logic [2:0] LOCK_N = 3'(LOCK_COUNT);
    localparam logic [2:0] LOSS_N = 3'(LOSS_COUNT);

    state_t     state;
    logic [9:0] shreg;
    logic [3:0] phase;
    logic [2:0] lock_cnt;
    logic [2:0] loss_cnt;

    logic [9:0] w;
    logic       match;
    logic       boundary;

    assign w        = {shreg[8:0], entrada};
    assign match    = (w == COMMA_P) || (w == COMMA_N);
    assign boundary = (phase == 4'd9);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= HUNT;
            shreg         <= '0;
            phase         <= '0;
            lock_cnt      <= '0;
            loss_cnt      <= '0;
            salidas       <= '0;
            validoSalida  <= 1'b0;
            sincronizado  <= 1'b0;
            comaDetectada <= 1'b0;
        end else begin
            validoSalida  <= 1'b0;
            comaDetectada <= 1'b0;
            if (enb) begin
                shreg <= w;
                phase <= boundary ? 4'd0 : phase + 4'd1;
                case (state)
                    HUNT: begin
                        if (match) begin
                            phase    <= 4'd0;
                            lock_cnt <= 3'd1;
                            if (LOCK_N == 3'd1) begin
                                state        <= LOCKED;
                                sincronizado <= 1'b1;
                                loss_cnt     <= 3'd0;
                            end else begin
                                state <= ALIGN;
                            end
                        end
                    end
                    ALIGN: begin
                        if (boundary) begin
                            if (match) begin
                                lock_cnt <= lock_cnt + 3'd1;
                                if (lock_cnt + 3'd1 == LOCK_N) begin
                                    state        <= LOCKED;
                                    sincronizado <= 1'b1;
                                    loss_cnt     <= 3'd0;
                                end
                            end else begin
                                state    <= HUNT;
                                lock_cnt <= 3'd0;
                            end
                        end else if (match) begin
                            phase    <= 4'd0;
                            lock_cnt <= 3'd1;
                        end
                    end
                    LOCKED: begin
                        if (boundary) begin
`ifdef FILTER_COMMA_EN
                            if (!match) begin
                                salidas      <= w;
                                validoSalida <= 1'b1;
                            end
`else
                            salidas      <= w;
                            validoSalida <= 1'b1;
`endif
                            comaDetectada <= match;
                            if (match)
                                loss_cnt <= 3'd0;
                        end else if (match) begin
                            // misplaced comma: count toward losing alignment
                            if (loss_cnt + 3'd1 == LOSS_N) begin
                                state        <= HUNT;
                                sincronizado <= 1'b0;
                                loss_cnt     <= 3'd0;
                                lock_cnt     <= 3'd0;
                            end else begin
                                loss_cnt <= loss_cnt + 3'd1;
                            end
                        end
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_serial_paralelo.sv
// Self-checking bench for serial_paralelo: directed scenarios plus random streams vs. a behavioural model.
// Honours FILTER_COMMA_EN in the model when the design is built with it.
module tb_serial_paralelo;

    localparam logic [9:0] CP    = 10'b0011111010;
    localparam logic [9:0] CN    = 10'b1100000101;
    localparam int         LOCKN = 3;
    localparam int         LOSSN = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enb = 1'b0;
    logic       entrada = 1'b0;
    logic [9:0] salidas;
    logic       validoSalida, sincronizado, comaDetectada;

    int n_cmp = 0;
    int n_bad = 0;

    serial_paralelo dut (
        .clk(clk), .rst(rst), .enb(enb), .entrada(entrada),
        .salidas(salidas), .validoSalida(validoSalida),
        .sincronizado(sincronizado), .comaDetectada(comaDetectada)
    );

    always #5 clk = ~clk;

    // model: bit history, aligned bit count, confirmation and miss tallies
    logic [9:0] m_hist;
    int         m_mode;      // 0 searching, 1 confirming, 2 aligned
    int         m_since;
    int         m_hits;
    int         m_miss;
    logic [9:0] m_word;
    logic       m_valid, m_coma;

    // observed pulse tallies for the directed scenarios
    int         n_valid, n_coma;
    logic [9:0] last_word;
    logic [9:0] words[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_hist = '0; m_mode = 0; m_since = 0; m_hits = 0; m_miss = 0;
        m_word = '0; m_valid = 1'b0; m_coma = 1'b0;
    endtask

    task automatic model_step(input logic b, input logic e);
        logic is_c, at_b;
        m_valid = 1'b0;
        m_coma  = 1'b0;
        if (!e) return;
        m_hist  = {m_hist[8:0], b};
        is_c    = (m_hist == CP) || (m_hist == CN);
        m_since = m_since + 1;
        at_b    = (m_since % 10) == 0;
        if (m_mode == 0) begin
            if (is_c) begin
                m_since = 0; m_hits = 1;
                if (m_hits == LOCKN) begin m_mode = 2; m_miss = 0; end
                else m_mode = 1;
            end
        end else if (m_mode == 1) begin
            if (at_b) begin
                if (is_c) begin
                    m_hits++;
                    if (m_hits == LOCKN) begin m_mode = 2; m_miss = 0; end
                end else begin
                    m_mode = 0; m_hits = 0;
                end
            end else if (is_c) begin
                m_since = 0; m_hits = 1;
            end
        end else begin
            if (at_b) begin
`ifdef FILTER_COMMA_EN
                if (!is_c) begin m_word = m_hist; m_valid = 1'b1; end
`else
                m_word = m_hist; m_valid = 1'b1;
`endif
                m_coma = is_c;
                if (is_c) m_miss = 0;
            end else if (is_c) begin
                m_miss++;
                if (m_miss == LOSSN) begin m_mode = 0; m_miss = 0; m_hits = 0; end
            end
        end
    endtask

    task automatic send_bit(input logic b, input logic e);
        entrada = b;
        enb     = e;
        @(posedge clk);
        #2;
        model_step(b, e);
        if (validoSalida) begin n_valid++; last_word = salidas; words.push_back(salidas); end
        if (comaDetectada) n_coma++;
        chk("valid", validoSalida, m_valid);
        chk("coma", comaDetectada, m_coma);
        chk("sinc", sincronizado, m_mode == 2);
        chk("salidas", salidas, m_word);
    endtask

    task automatic send_word(input logic [9:0] wd);
        for (int i = 9; i >= 0; i--) send_bit(wd[i], 1'b1);
    endtask

    task automatic clear_tally();
        n_valid = 0; n_coma = 0; words.delete();
    endtask

    task automatic do_reset();
        #1 rst = 1'b1;
        #1;
        chk("rst_out", {salidas, validoSalida, sincronizado, comaDetectada}, 13'd0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
    endtask

    initial begin
        model_reset();
        clear_tally();
        last_word = '0;
        #200;
        chk("reset_state", {salidas, validoSalida, sincronizado, comaDetectada}, 13'd0);
        @(negedge clk);
        rst = 1'b0;

        // 1: lock acquisition, first data word
        for (int i = 0; i < 3; i++) send_bit(1'b0, 1'b1);
        send_word(CP); send_word(CP);
        send_word(CP);
        chk("t1_locked", sincronizado, 1'b1);
        clear_tally();
        for (int i = 9; i >= 1; i--) send_bit(1'b1 & 10'b1101101100 >> i, 1'b1);
        chk("t1_early", n_valid, 0);
        send_bit(1'b0, 1'b1);
        chk("t1_count", n_valid, 1);
        chk("t1_word", last_word, 10'b1101101100);

        // 2: both disparities, ordered output, then an aborted alignment
        do_reset();
        send_word(CP); send_word(CN); send_word(CP);
        chk("t2_locked", sincronizado, 1'b1);
        clear_tally();
        send_word(10'b1111100000);
        send_word(10'b0000011111);
        chk("t2_count", n_valid, 2);
        if (words.size() == 2) begin
            chk("t2_w0", words[0], 10'b1111100000);
            chk("t2_w1", words[1], 10'b0000011111);
        end
        do_reset();
        send_word(CN);
        clear_tally();
        send_word(CP);
        send_word(10'b1010010101);
        chk("t2_abort_sinc", sincronizado, 1'b0);
        chk("t2_abort_valid", n_valid, 0);

        // 3: loss of sync after a 3-bit slip, then relock on the new phase
        do_reset();
        send_word(CP); send_word(CN); send_word(CP);
        send_word(10'b1101101100);
        send_bit(1'b1, 1'b1); send_bit(1'b0, 1'b1); send_bit(1'b1, 1'b1);
        for (int i = 0; i < 3; i++) send_word(CP);
        chk("t3_still", sincronizado, 1'b1);
        send_word(CP);
        chk("t3_lost", sincronizado, 1'b0);
        send_word(CP); send_word(CP);
        chk("t3_not_yet", sincronizado, 1'b0);
        send_word(CP);
        chk("t3_relock", sincronizado, 1'b1);
        clear_tally();
        send_word(10'b0110011001);
        chk("t3_word", last_word, 10'b0110011001);

        // 4: freeze for 7 cycles after bit 5 of a word
        clear_tally();
        for (int i = 9; i >= 5; i--) send_bit(1'b1 & 10'b1001110010 >> i, 1'b1);
        for (int i = 0; i < 7; i++) send_bit(1'b1, 1'b0);
        chk("t4_frozen", n_valid, 0);
        for (int i = 4; i >= 1; i--) send_bit(1'b1 & 10'b1001110010 >> i, 1'b1);
        chk("t4_early", n_valid, 0);
        send_bit(1'b0, 1'b1);
        chk("t4_count", n_valid, 1);
        chk("t4_word", last_word, 10'b1001110010);

        // 5: asynchronous reset mid-word while locked
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b1);
        chk("t5_pre", sincronizado, 1'b1);
        do_reset();
        clear_tally();
        for (int i = 0; i < 25; i++) send_bit(1'b0, 1'b1);
        chk("t5_quiet", n_valid, 0);

        // 6: comma words inside a locked stream
        send_word(CP); send_word(CN); send_word(CP);
        clear_tally();
        send_word(CN);
        send_word(10'b1101101101);
        send_word(CP);
        chk("t6_coma", n_coma, 2);
`ifdef FILTER_COMMA_EN
        chk("t6_valid", n_valid, 1);
`else
        chk("t6_valid", n_valid, 3);
`endif
        chk("t6_word", words.size() > 0 ? words[words.size() > 1 ? 1 : 0] : 10'h3ff,
`ifdef FILTER_COMMA_EN
            10'b1101101101);
`else
            10'b1101101101 & 10'h3ff);
`endif

        // random streams: mix of commas and data, slips, freezes, occasional resets
        for (int n = 0; n < 300; n++) begin
            logic [9:0] wd;
            int r;
            r = $urandom_range(0, 99);
            if (r < 3) do_reset();
            else if (r < 9) begin
                for (int k = 0, s = $urandom_range(1, 9); k < s; k++) send_bit(1'($urandom), 1'b1);
            end
            if ($urandom_range(0, 2) == 0) wd = $urandom_range(0, 1) ? CP : CN;
            else wd = 10'($urandom);
            for (int i = 9; i >= 0; i--) begin
                while ($urandom_range(0, 9) == 0) send_bit(1'($urandom), 1'b0);
                send_bit(wd[i], 1'b1);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/serial_paralelo.md
Name: serial_paralelo

Overview:
- Receive end of the 10-bit serial link; inverse of the parallel-to-serial emitter.
- Samples one bit per clk, hunts for a K28.5 comma to find word alignment, confirms lock, then presents each recovered 10-bit symbol with a one-cycle valid strobe.
- Sits between the serial line and the 8b/10b decoder.
- Bit order: MSB first, so the first received bit of a word lands in salidas[9].

Parameters:
- COMMA_P, 10'b0011111010, comma pattern, RD- form of K28.5.
- COMMA_N, 10'b1100000101, comma pattern, RD+ form of K28.5.
- LOCK_COUNT, 3, consecutive boundary-aligned commas required to declare lock (range 1..7).
- LOSS_COUNT, 4, off-boundary commas while locked that force re-hunt (range 1..7).

Ports:
- clk  input  1  bit clock; the single clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- enb  input  1  enable; low freezes all state.
- entrada  input  1  serial data bit, sampled every enabled rising edge.
- salidas  output  10  last recovered word, first-received bit in [9].
- validoSalida  output  1  one-cycle strobe: salidas holds a new word.
- sincronizado  output  1  high while in LOCKED.
- comaDetectada  output  1  one-cycle strobe: the word just output is a comma.

Behaviour:
- Reset: salidas=0, validoSalida=0, sincronizado=0, comaDetectada=0, shift register=0, phase=0, counters=0, state=HUNT. The reset is asynchronous and acts immediately, including mid-word.
- Window: w = {shreg[8:0], entrada}. shreg <= w on every enabled edge.
- Comma match: w==COMMA_P or w==COMMA_N.
- Phase counter: 0..9, increments each enabled edge, wraps 9->0. A "boundary" is the edge where phase==9.
- HUNT:
  - Phase is don't-care.
  - On any comma match: phase<=0, lockCnt<=1, state<=ALIGN. If LOCK_COUNT==1, state<=LOCKED instead.
- ALIGN:
  - At a boundary with a comma: lockCnt++. Reaching LOCK_COUNT -> LOCKED, lossCnt<=0.
  - At a boundary with a non-comma: -> HUNT, lockCnt<=0.
  - A comma at a non-boundary: re-align there (phase<=0, lockCnt<=1), stay in ALIGN.
- LOCKED:
  - Each boundary: salidas<=w and validoSalida<=1 for exactly one cycle. comaDetectada<=match in the same cycle.
  - A comma at a boundary clears lossCnt.
  - A comma at a non-boundary increments lossCnt. Reaching LOSS_COUNT -> HUNT, with sincronizado=0 from the next cycle. No word is output on that edge.
  - Simultaneous events: a boundary comma always wins; it clears lossCnt.
- Latency: validoSalida rises on the edge that samples the 10th bit of a word. In LOCKED it pulses every 10 enabled cycles.
- Outside LOCKED: validoSalida=0 and comaDetectada=0. salidas holds its last value.
- enb=0:
  - No shift, no phase advance, no state change.
  - validoSalida and comaDetectada are forced 0.
  - The freeze is transparent: resuming continues the word exactly.
- sincronizado is a registered output of state==LOCKED.

Optional Feature:
- Macro: FILTER_COMMA_EN.
- Defined: in LOCKED, boundary words equal to either comma do not assert validoSalida. salidas is not updated. comaDetectada still pulses.
- Undefined: comma words are output like data, with validoSalida=1 and comaDetectada=1.

Test Plan:
1. Lock acquisition:
   - Stimulus: rst high 200 ns, release; 3 garbage bits, then COMMA_P x3, then 10'b1101101100.
   - Required: sincronizado rises after the 3rd comma. salidas=10'b1101101100 with one validoSalida pulse exactly 10 cycles later.
2. Both disparities, plus an ALIGN abort:
   - Stimulus: alternate COMMA_P/COMMA_N x3, then data 10'b1111100000, 10'b0000011111.
   - Required: lock; words output in order, each with a single-cycle strobe 10 cycles apart.
   - Then, in ALIGN, send COMMA_P then 10'b1010010101. Required: return to HUNT, no validoSalida.
3. Loss of sync:
   - Stimulus: after lock, shift the stream by 3 bits and send 4 commas.
   - Required: sincronizado falls after the 4th misaligned comma. The FSM re-locks on the new phase after 3 more commas.
4. enb freeze:
   - Stimulus: while locked, drop enb for 7 cycles mid-word (bit 5), holding entrada.
   - Required: no strobe while enb=0. The next word completes exactly 5 enabled cycles after resume, value intact.
5. Reset mid-operation:
   - Stimulus: assert rst asynchronously between clk edges mid-word while locked.
   - Required: all outputs 0 immediately; HUNT after release; no spurious validoSalida.
6. FILTER_COMMA_EN:
   - Stimulus: with the macro defined, locked stream of comma, 10'b1101101101, comma.
   - Required: validoSalida only for 10'b1101101101; comaDetectada pulses twice.
   - Without the macro: three validoSalida pulses.
